rs_syndrome_calc: RTL

Receive-side front end of the RS(255,239) decoder over GF(2^8), the counterpart of the parity-generating encoder LFSR. It accepts one received codeword symbol per valid cycle, highest-degree symbol first. It accumulates all NSYM syndromes in parallel using Horner's rule with constant-alpha multipliers. After the last symbol it presents a registered syndrome vector and a nonzero flag to the downstream key-equation solver.

---
 rtl/rs_syndrome_calc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) receive-side syndrome calculator over GF(2^8), poly 0x11D.
// Horner accumulation of S_1..S_NSYM with constant alpha^i XOR networks.
module rs_syndrome_calc #(
  parameter int N    = 255,
  parameter int NSYM = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic [7:0]          in_data,
  output logic                syn_valid,
  output logic [8*NSYM-1:0]   syn_data,
  output logic                syn_nonzero,
  output logic                sop_err,
  output logic                busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Multiply by alpha in GF(2^8) with reduction by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
  endfunction

  // Column j of the returned matrix is alpha^p * x^j; constant-folded per syndrome.
  function automatic logic [63:0] alpha_pow_matrix(input int p);
    logic [63:0] m;
    logic [7:0]  col;
    m = 64'h0;
    for (int j = 0; j < 8; j++) begin
      col = 8'h01 << j;
      for (int k = 0; k < p; k++) begin
        col = gf_xtime(col);
      end
      m[j*8 +: 8] = col;
    end
    return m;
  endfunction

  function automatic logic [7:0] mat_mul(input logic [63:0] m, input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      r = r ^ (m[j*8 +: 8] & {8{a[j]}});
    end
    return r;
  endfunction

  state_t                  state_r, state_nx_s;
  logic [7:0]              cnt_r, cnt_nx_s;
  logic [NSYM-1:0][7:0]    acc_r, acc_nx_s, acc_step_s;
  logic                    done_s;
  logic                    sop_err_nx_s;

  for (genvar g = 0; g < NSYM; g++) begin : g_syn
    localparam logic [63:0] MAT = alpha_pow_matrix(g + 1);
    assign acc_step_s[g] = mat_mul(MAT, acc_r[g]) ^ in_data;
  end

  // Next-state, accumulator update and completion detection.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    acc_nx_s     = acc_r;
    done_s       = 1'b0;
    sop_err_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_sop) begin
          acc_nx_s   = {NSYM{in_data}};
          cnt_nx_s   = 8'd1;
          state_nx_s = ACC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACC: begin
        if (in_valid && in_sop) begin
          // restart: the aborted word never completes
          acc_nx_s     = {NSYM{in_data}};
          cnt_nx_s     = 8'd1;
          sop_err_nx_s = 1'b1;
        end else if (in_valid) begin
          acc_nx_s = acc_step_s;
          if (cnt_r == 8'(N - 1)) begin
            done_s     = 1'b1;
            cnt_nx_s   = 8'd0;
            state_nx_s = IDLE;
          end else begin
            cnt_nx_s = cnt_r + 8'd1;
          end
        end else begin
          state_nx_s = ACC;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 8'd0;
      end
    endcase
  end

  // State, accumulators and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      acc_r       <= '0;
      syn_data    <= '0;
      syn_valid   <= 1'b0;
      syn_nonzero <= 1'b0;
      sop_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      acc_r     <= acc_nx_s;
      syn_valid <= done_s;
      sop_err   <= sop_err_nx_s;
      busy      <= (state_nx_s == ACC);
      if (done_s) begin
        syn_data    <= acc_step_s;
        syn_nonzero <= |acc_step_s;
      end else begin
        syn_data    <= syn_data;
        syn_nonzero <= syn_nonzero;
      end
    end
  end

endmodule
